// File: rtl/serial_compare_loader_if.sv
// serial_compare_loader_if: serial operand lines, parallel operand
// words and comparator result bundle for the serial compare loader.
interface serial_compare_loader_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sdata_a;
  logic             sdata_b;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             busy;
  logic             valid;
  logic             eq_in;
  logic             gt_in;
  logic             lt_in;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;
  logic             res_valid;

  modport master (
    output start, sdata_a, sdata_b,
    output eq_in, gt_in, lt_in,
    input  a_out, b_out, busy, valid,
    input  eq_q, gt_q, lt_q, res_valid
  );

  modport slave (
    input  start, sdata_a, sdata_b,
    input  eq_in, gt_in, lt_in,
    output a_out, b_out, busy, valid,
    output eq_q, gt_q, lt_q, res_valid
  );
endinterface

// File: rtl/serial_compare_loader.sv
// serial_compare_loader: MSB-first deserialiser feeding the comparator.
// Define CMP_RESULT_LATCH_EN to register eq/gt/lt once per load.
module serial_compare_loader #(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  serial_compare_loader_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sr_a;
  logic [WIDTH-1:0] sr_b;
  logic [WIDTH-1:0] sr_a_nxt;
  logic [WIDTH-1:0] sr_b_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             accept;
  logic             last;

  // Next state, counter and shift-register contents.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_a_nxt  = sr_a;
    sr_b_nxt  = sr_b;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
          cnt_nxt   = CW'(1);
          sr_a_nxt  = WIDTH'(bus.sdata_a);
          sr_b_nxt  = WIDTH'(bus.sdata_b);
        end
      end
      SHIFT: begin
        sr_a_nxt = (sr_a << 1) | WIDTH'(bus.sdata_a);
        sr_b_nxt = (sr_b << 1) | WIDTH'(bus.sdata_b);
        if (cnt == LAST) begin
          // Counter parks at LAST so it never wraps.
          last      = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr_a  <= '0;
      sr_b  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr_a  <= sr_a_nxt;
      sr_b  <= sr_b_nxt;
    end
  end

  // Parallel words update only when a pair is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (last) begin
      a_q <= sr_a_nxt;
      b_q <= sr_b_nxt;
    end
  end

  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.busy  = (state == SHIFT);
  assign bus.valid = (state == DONE);

`ifdef CMP_RESULT_LATCH_EN
  logic eq_r;
  logic gt_r;
  logic lt_r;
  logic res_r;

  // Capture the comparator once, on the first DONE edge of a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_r  <= 1'b0;
      gt_r  <= 1'b0;
      lt_r  <= 1'b0;
      res_r <= 1'b0;
    end else if (accept) begin
      eq_r  <= 1'b0;
      gt_r  <= 1'b0;
      lt_r  <= 1'b0;
      res_r <= 1'b0;
    end else if (state == DONE && !res_r) begin
      eq_r  <= bus.eq_in;
      gt_r  <= bus.gt_in;
      lt_r  <= bus.lt_in;
      res_r <= 1'b1;
    end
  end

  assign bus.eq_q      = eq_r;
  assign bus.gt_q      = gt_r;
  assign bus.lt_q      = lt_r;
  assign bus.res_valid = res_r;
`else
  logic unused_accept;

  assign unused_accept = accept;
  assign bus.eq_q      = bus.eq_in & bus.valid;
  assign bus.gt_q      = bus.gt_in & bus.valid;
  assign bus.lt_q      = bus.lt_in & bus.valid;
  assign bus.res_valid = bus.valid;
`endif

endmodule

// File: tb/tb_serial_compare_loader.sv
// tb_serial_compare_loader: scoreboard bench for serial_compare_loader.
// Works with CMP_RESULT_LATCH_EN defined or undefined.
module tb_serial_compare_loader;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           t0;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;
  int   busy_cnt;
  bit   valid_d;
  bit   res_d;
  bit   have_prev;
  logic [W-1:0] prev_a;
  logic [W-1:0] prev_b;
  bit   f_en;
  logic f_eq;
  logic f_gt;
  logic f_lt;
  exp_t sb[$];
  exp_t cur;
  exp_t last_e;

  serial_compare_loader_if #(.WIDTH(W)) bus ();

  serial_compare_loader #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side comparator, overridable with forced values.
  always_comb begin
    if (f_en) begin
      bus.eq_in = f_eq;
      bus.gt_in = f_gt;
      bus.lt_in = f_lt;
    end else begin
      bus.eq_in = (bus.a_out == bus.b_out);
      bus.gt_in = (bus.a_out > bus.b_out);
      bus.lt_in = (bus.a_out < bus.b_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pop expectations when a pair completes.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt  = 0;
      valid_d   = 0;
      res_d     = 0;
      have_prev = 0;
    end else begin
      if (bus.busy) begin
        busy_cnt++;
        if (have_prev) begin
          chk("hold_a", bus.a_out, prev_a);
          chk("hold_b", bus.b_out, prev_b);
        end
      end
      if (bus.valid && !valid_d) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("a_out", bus.a_out, cur.a);
          chk("b_out", bus.b_out, cur.b);
          chk("valid_time", cyc, cur.t0 + W);
          chk("busy_len", busy_cnt, W - 1);
          chk("busy_off", bus.busy, 0);
`ifndef CMP_RESULT_LATCH_EN
          chk("res_valid", bus.res_valid, 1);
          chk("eq_q", bus.eq_q, cur.a == cur.b);
          chk("gt_q", bus.gt_q, cur.a > cur.b);
          chk("lt_q", bus.lt_q, cur.a < cur.b);
`endif
          prev_a    = cur.a;
          prev_b    = cur.b;
          have_prev = 1;
          last_e    = cur;
        end
        busy_cnt = 0;
      end
`ifdef CMP_RESULT_LATCH_EN
      if (bus.res_valid && !res_d) begin
        chk("res_time", cyc, last_e.t0 + W + 1);
        chk("eq_q", bus.eq_q, last_e.a == last_e.b);
        chk("gt_q", bus.gt_q, last_e.a > last_e.b);
        chk("lt_q", bus.lt_q, last_e.a < last_e.b);
      end
`endif
      valid_d = bus.valid;
      res_d   = bus.res_valid;
    end
  end

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit hold, input bit gate);
    exp_t e;
    bus.start   = 1'b1;
    bus.sdata_a = a[W-1];
    bus.sdata_b = b[W-1];
    e.a  = a;
    e.b  = b;
    e.t0 = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = hold;
    chk("busy_c1", bus.busy, 1);
    chk("valid_c1", bus.valid, 0);
    if (gate) begin
      chk("res_drop", bus.res_valid, 0);
`ifndef CMP_RESULT_LATCH_EN
      chk("eq_gate", bus.eq_q, 0);
      chk("gt_gate", bus.gt_q, 0);
      chk("lt_gate", bus.lt_q, 0);
`endif
      f_en = 0;
    end
    for (int i = W - 2; i >= 0; i--) begin
      bus.sdata_a = a[i];
      bus.sdata_b = b[i];
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, bus.a_out, 0);
    chk({tag, "_b"}, bus.b_out, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_eq"}, bus.eq_q, 0);
    chk({tag, "_gt"}, bus.gt_q, 0);
    chk({tag, "_lt"}, bus.lt_q, 0);
    chk({tag, "_res"}, bus.res_valid, 0);
  endtask

  initial begin
    cyc = 0;
    n_chk = 0;
    n_err = 0;
    f_en = 0;
    f_eq = 0;
    f_gt = 0;
    f_lt = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sdata_a = 1'b0;
    bus.sdata_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;
    idle(1);

    load(4'b1011, 4'b0110, 0, 0);
    idle(W + 2);
    load(4'b0101, 4'b0101, 0, 0);
    idle(2);
    load(4'b0011, 4'b1100, 0, 0);
    idle(W + 2);

    load(4'b0010, 4'b0111, 1, 0);
    idle(W + 2);
    chk("one_load", sb.size(), 0);
    chk("hold_valid", bus.valid, 1);
    chk("hold_busy", bus.busy, 0);

    load(4'b1100, 4'b0011, 0, 0);
    load(4'b0001, 4'b1000, 0, 0);
    idle(W + 2);

    bus.start = 1'b1;
    bus.sdata_a = 1'b1;
    bus.sdata_b = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    #1;
    rst = 1'b0;
    idle(1);
    load(4'b1001, 4'b0100, 0, 0);
    idle(W + 2);

`ifdef CMP_RESULT_LATCH_EN
    f_eq = 1;
    f_gt = 0;
    f_lt = 1;
    f_en = 1;
    idle(2);
    chk("latch_eq", bus.eq_q, 0);
    chk("latch_gt", bus.gt_q, 1);
    chk("latch_lt", bus.lt_q, 0);
`else
    f_eq = 1;
    f_gt = 0;
    f_lt = 1;
    f_en = 1;
    #1;
    chk("force_eq", bus.eq_q, 1);
    chk("force_gt", bus.gt_q, 0);
    chk("force_lt", bus.lt_q, 1);
    f_eq = 0;
    f_gt = 1;
    #1;
    chk("force_eq2", bus.eq_q, 0);
    chk("force_gt2", bus.gt_q, 1);
    f_eq = 1;
    f_gt = 1;
    f_lt = 1;
    #1;
`endif
    load(4'b0110, 4'b0111, 0, 1);
    idle(W + 2);
    chk("drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
